// File: rtl/dot_product_pkg.sv
// Shared widths, derived sizes, phase encoding and the per-lane MAC helper
// for the dot_product element-wise multiply-accumulate engine.
package dot_product_pkg;

  localparam int unsigned ADDR_WIDTH           = 5;
  localparam int unsigned RAM_DEPTH            = 1 << ADDR_WIDTH;
  localparam int unsigned NUMS_SRAM_IN         = 2;
  localparam int unsigned NUMS_SRAM_OUT        = 1;
  localparam int unsigned NUMS_SRAM            = NUMS_SRAM_IN + NUMS_SRAM_OUT;
  localparam int unsigned NUMS_DATA_IN_BITS    = 5;
  localparam int unsigned NUMS_DATA            = 1 << NUMS_DATA_IN_BITS;
  localparam int unsigned NUMS_PIPELINE_STAGES = 4;
  localparam int unsigned PIPELINE_TAIL        = NUMS_PIPELINE_STAGES - 1;
  localparam int unsigned TOTAL_STEPS          = NUMS_DATA + PIPELINE_TAIL;
  localparam int unsigned PARA_DEG             = 1;
  localparam int unsigned DATA_WIDTH_IN        = 8;
  localparam int unsigned DATA_WIDTH_OUT       = 16;

  // Short aliases used throughout the datapath
  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned DWI   = DATA_WIDTH_IN;
  localparam int unsigned DWO   = DATA_WIDTH_OUT;
  localparam int unsigned P     = PARA_DEG;
  localparam int unsigned WORDS = RAM_DEPTH / PARA_DEG;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DUMP
  } phase_t;

  // One lane: a*b + c, wrapped to the output width
  function automatic logic [DWO-1:0] lane_mac(input logic [DWI-1:0] a,
                                              input logic [DWI-1:0] b,
                                              input logic [DWO-1:0] c);
    logic [2*DWI-1:0] prod;
    prod = a * b;
    return DWO'(prod) + c;
  endfunction

endpackage

// File: rtl/dot_product_if.sv
// Host-facing control, data and observation signals of dot_product.
interface dot_product_if;
  import dot_product_pkg::*;

  logic                                 Computing;
  logic                                 load_old_output;
  logic                                 load_from_file;
  logic                                 write_to_file;
  logic [NUMS_SRAM_IN*P*DWI-1:0]        input_data_from_file;
  logic [NUMS_SRAM_OUT*P*DWO-1:0]       output_data_from_file;
  logic [NUMS_SRAM_OUT*P*DWO-1:0]       output_data_to_file;
  logic [P*DWO-1:0]                     result;
  logic [NUMS_DATA_IN_BITS:0]           state;
  logic [NUMS_SRAM*AW-1:0]              test_r;
  logic [NUMS_SRAM*AW-1:0]              test_w;
  logic [NUMS_SRAM_IN*P*DWI-1:0]        test_data;
  logic                                 en_write_test;
  logic [AW:0]                          mem_index_test;
  logic                                 test_en_read;
  logic                                 test_signal;

  modport master (
    output Computing, load_old_output, load_from_file, write_to_file,
           input_data_from_file, output_data_from_file,
    input  output_data_to_file, result, state, test_r, test_w, test_data,
           en_write_test, mem_index_test, test_en_read, test_signal
  );

  modport slave (
    input  Computing, load_old_output, load_from_file, write_to_file,
           input_data_from_file, output_data_from_file,
    output output_data_to_file, result, state, test_r, test_w, test_data,
           en_write_test, mem_index_test, test_en_read, test_signal
  );

endinterface

// File: rtl/dp_sram.sv
// Simple dual-port SRAM: one write port, one registered read port.
// Read data holds when no read is enabled.
module dp_sram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dot_product.sv
// Element-wise multiply-accumulate engine: loads A, B and initial C from the
// host, computes C[i] = A[i]*B[i] (+ old C[i]) through a 4-stage pipeline
// (issue, SRAM read, MAC, write-back) and streams C back out.
module dot_product
  import dot_product_pkg::*;
(
  input  logic         clk,
  input  logic         Mem_reset,
  input  logic         Comp_reset,
  input  logic         PE_reset,
  input  logic         Mem_Index_reset,
  dot_product_if.slave bus
);

  localparam int unsigned SW = NUMS_DATA_IN_BITS + 1;
  localparam int unsigned IW = AW + 1;
  localparam int unsigned WI = P * DWI;
  localparam int unsigned WO = P * DWO;
  localparam logic [SW-1:0] LAST_STEP   = SW'(TOTAL_STEPS);
  localparam logic [SW-1:0] ISSUE_LIMIT = SW'(WORDS);
  localparam logic [IW-1:0] INDEX_END   = IW'(WORDS);
  localparam logic [IW-1:0] INDEX_LAST  = IW'(WORDS - 1);

  phase_t        mem_phase;
  phase_t        phase;
  logic [SW-1:0] state_q;
  logic [SW-1:0] issue_idx;
  logic [IW-1:0] mem_index_q;
  logic          busy;
  logic          comp_rst;
  logic          issue_v;
  logic          load_we;
  logic          dump_re;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] load_addr;

  logic          v2, v3, v4;
  logic [AW-1:0] a2, a3, a4;
  logic [WO-1:0] s3_q;
  logic [WO-1:0] result_q;
  logic [WO-1:0] mac_word;

  logic [WI-1:0] in_rd [NUMS_SRAM_IN];
  logic [WO-1:0] c_rd;
  logic          c_we;
  logic          c_re;
  logic [AW-1:0] c_waddr;
  logic [AW-1:0] c_raddr;
  logic [WO-1:0] c_wdata;

  // Either pipeline or counter reset aborts the compute phase
  assign comp_rst = Comp_reset | PE_reset;

  assign busy       = (state_q != '0);
  assign phase      = busy ? COMPUTE : mem_phase;
  assign issue_idx  = state_q - SW'(1);
  assign issue_v    = busy && (issue_idx < ISSUE_LIMIT);
  assign issue_addr = issue_idx[AW-1:0];
  assign load_addr  = mem_index_q[AW-1:0];
  assign load_we    = (phase == LOAD);
  assign dump_re    = (phase == DUMP) && (mem_index_q < INDEX_END);

  // Load / read-out sequencing and the shared index counter
  always_ff @(posedge clk or posedge Mem_reset) begin
    if (Mem_reset) begin
      mem_phase   <= IDLE;
      mem_index_q <= '0;
    end else begin
      case (mem_phase)
        IDLE: begin
          if (!busy && !bus.Computing) begin
            if (bus.load_from_file) begin
              mem_phase   <= LOAD;
              mem_index_q <= '0;
            end else if (bus.write_to_file) begin
              mem_phase <= DUMP;
            end
          end
        end
        LOAD: begin
          mem_index_q <= mem_index_q + IW'(1);
          if (mem_index_q == INDEX_LAST) mem_phase <= IDLE;
        end
        DUMP: begin
          if (mem_index_q < INDEX_END) mem_index_q <= mem_index_q + IW'(1);
          if (mem_index_q >= INDEX_LAST) mem_phase <= IDLE;
        end
        default: mem_phase <= IDLE;
      endcase
      if (Mem_Index_reset) mem_index_q <= '0;
    end
  end

  // Compute step counter: 1..TOTAL_STEPS while busy, 0 otherwise
  always_ff @(posedge clk or posedge comp_rst) begin
    if (comp_rst)                                   state_q <= '0;
    else if (busy)                                  state_q <= (state_q == LAST_STEP) ? '0 : state_q + SW'(1);
    else if (bus.Computing && mem_phase == IDLE)    state_q <= SW'(1);
  end

  // MAC on the registered SRAM words, lane by lane
  always_comb begin
    mac_word = '0;
    for (int unsigned l = 0; l < P; l++) begin
      mac_word[l*DWO +: DWO] = lane_mac(in_rd[0][l*DWI +: DWI], in_rd[1][l*DWI +: DWI],
                                        bus.load_old_output ? c_rd[l*DWO +: DWO] : '0);
    end
  end

  // Pipeline valids gate on busy so an aborted compute drops in-flight ops;
  // the op already in write-back still lands.
  always_ff @(posedge clk or posedge PE_reset) begin
    if (PE_reset) begin
      v2       <= 1'b0;
      v3       <= 1'b0;
      v4       <= 1'b0;
      a2       <= '0;
      a3       <= '0;
      a4       <= '0;
      s3_q     <= '0;
      result_q <= '0;
    end else begin
      v2   <= issue_v;
      a2   <= issue_addr;
      v3   <= v2 && busy;
      a3   <= a2;
      s3_q <= mac_word;
      v4   <= v3 && busy;
      a4   <= a3;
      if (v3 && busy) result_q <= s3_q;
    end
  end

  assign c_we    = load_we | v4;
  assign c_waddr = load_we ? load_addr : a4;
  assign c_wdata = load_we ? bus.output_data_from_file : result_q;
  assign c_re    = issue_v | dump_re;
  assign c_raddr = (phase == COMPUTE) ? issue_addr : load_addr;

  for (genvar k = 0; k < NUMS_SRAM_IN; k++) begin : g_in_sram
    dp_sram #(.DATA_W(WI), .ADDR_W(AW)) u_sram (
      .clk   (clk),
      .rst   (Mem_reset),
      .we    (load_we),
      .waddr (load_addr),
      .wdata (bus.input_data_from_file[k*WI +: WI]),
      .re    (issue_v),
      .raddr (issue_addr),
      .rdata (in_rd[k])
    );
    assign bus.test_data[k*WI +: WI] = in_rd[k];
  end

  dp_sram #(.DATA_W(WO), .ADDR_W(AW)) u_c_sram (
    .clk   (clk),
    .rst   (Mem_reset),
    .we    (c_we),
    .waddr (c_waddr),
    .wdata (c_wdata),
    .re    (c_re),
    .raddr (c_raddr),
    .rdata (c_rd)
  );

  // Per-SRAM address observation buses
  always_comb begin
    bus.test_r = '0;
    bus.test_w = '0;
    for (int unsigned k = 0; k < NUMS_SRAM_IN; k++) begin
      bus.test_r[k*AW +: AW] = issue_addr;
      bus.test_w[k*AW +: AW] = load_addr;
    end
    bus.test_r[NUMS_SRAM_IN*AW +: AW] = c_raddr;
    bus.test_w[NUMS_SRAM_IN*AW +: AW] = c_waddr;
  end

  assign bus.output_data_to_file = c_rd;
  assign bus.result              = result_q;
  assign bus.state               = state_q;
  assign bus.en_write_test       = c_we;
  assign bus.mem_index_test      = mem_index_q;
  assign bus.test_en_read        = c_re;
  assign bus.test_signal         = busy;

endmodule

// File: tb/tb_dot_product.sv
// Scoreboard bench for dot_product: stimulus tasks push expected write-backs
// and read-out words into queues; a monitor pops and compares them.
module tb_dot_product;
  import dot_product_pkg::*;

  logic clk = 1'b0;
  logic Mem_reset, Comp_reset, PE_reset, Mem_Index_reset;

  dot_product_if bus();

  dot_product dut (
    .clk             (clk),
    .Mem_reset       (Mem_reset),
    .Comp_reset      (Comp_reset),
    .PE_reset        (PE_reset),
    .Mem_Index_reset (Mem_Index_reset),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ref_a [WORDS];
  int ref_b [WORDS];
  int ref_c [WORDS];

  typedef struct { int addr; int val; } wb_t;
  wb_t exp_wb[$];
  int  exp_dump[$];
  bit  tb_loading = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compute write-backs and read-out words against the queues
  initial begin
    bit dump_pending;
    dump_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (dump_pending) begin
        if (exp_dump.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dump_extra: got word %0d, expected none", bus.output_data_to_file);
        end else begin
          int e;
          e = exp_dump.pop_front();
          check("dump_word", 32'(bus.output_data_to_file), e);
        end
      end
      dump_pending = bus.test_en_read && !bus.test_signal;
      if (bus.en_write_test && !tb_loading) begin
        if (exp_wb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got C[%0d] <= %0d, expected no write",
                   bus.test_w[2*AW +: AW], bus.result);
        end else begin
          wb_t w;
          w = exp_wb.pop_front();
          check("wb_addr", 32'(bus.test_w[2*AW +: AW]), w.addr);
          check("wb_data", 32'(bus.result), w.val);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_word(input int k);
    bus.input_data_from_file  = {DWI'(ref_b[k]), DWI'(ref_a[k])};
    bus.output_data_from_file = DWO'(ref_c[k]);
  endtask

  task automatic load_vectors();
    tb_loading = 1'b1;
    @(posedge clk); #1 bus.load_from_file = 1'b1;
    @(posedge clk); #1 bus.load_from_file = 1'b0;
    drive_word(0);
    for (int k = 1; k < WORDS; k++) begin
      @(posedge clk); #1 drive_word(k);
    end
    @(posedge clk); #1;
    tb_loading = 1'b0;
    check("load_end_index", 32'(bus.mem_index_test), WORDS);
    check("load_we_low", 32'(bus.en_write_test), 0);
  endtask

  task automatic start_compute(input bit acc);
    @(posedge clk); #1;
    bus.load_old_output = acc;
    bus.Computing       = 1'b1;
    @(posedge clk); #1 bus.Computing = 1'b0;
    check("state_first_step", 32'(bus.state), 1);
  endtask

  task automatic run_compute(input bit acc, input bit poke);
    int cycles;
    int max_state;
    bit done;
    cycles = 0;
    max_state = 0;
    done = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      wb_t w;
      ref_c[i] = ((acc ? ref_c[i] : 0) + ref_a[i] * ref_b[i]) % (1 << DWO);
      w.addr = i;
      w.val  = ref_c[i];
      exp_wb.push_back(w);
    end
    start_compute(acc);
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus.test_signal) begin
        cycles++;
        if (int'(bus.state) > max_state) max_state = int'(bus.state);
        if (poke) begin
          bus.Computing      = (bus.state == 5);
          bus.load_from_file = (bus.state == 5);
        end
      end else begin
        done = 1'b1;
      end
    end
    bus.Computing      = 1'b0;
    bus.load_from_file = 1'b0;
    check("compute_finished", 32'(done), 1);
    check("busy_cycles", cycles, TOTAL_STEPS);
    check("max_state", max_state, TOTAL_STEPS);
    check("state_idle", 32'(bus.state), 0);
    check("index_untouched", 32'(bus.mem_index_test), WORDS);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_abort(input bit acc);
    for (int i = 0; i < 7; i++) begin
      wb_t w;
      ref_c[i] = ((acc ? ref_c[i] : 0) + ref_a[i] * ref_b[i]) % (1 << DWO);
      w.addr = i;
      w.val  = ref_c[i];
      exp_wb.push_back(w);
    end
    start_compute(acc);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.state == 10) break;
    end
    check("abort_reached_step", 32'(bus.state), 10);
    #1 Comp_reset = 1'b1;
    #1;
    check("abort_state_async", 32'(bus.state), 0);
    check("abort_busy_low", 32'(bus.test_signal), 0);
    @(negedge clk);
    Comp_reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_dump();
    for (int i = 0; i < WORDS; i++) exp_dump.push_back(ref_c[i]);
    @(posedge clk); #1;
    Mem_Index_reset   = 1'b1;
    bus.write_to_file = 1'b1;
    @(posedge clk); #1;
    Mem_Index_reset   = 1'b0;
    bus.write_to_file = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_dump.size() == 0) break;
    end
    check("dump_drained", exp_dump.size(), 0);
    exp_dump.delete();
    repeat (2) @(negedge clk);
    check("dump_hold_last", 32'(bus.output_data_to_file), ref_c[WORDS-1]);
  endtask

  task automatic fill_pattern(input int a_mode, input int b, input int c);
    for (int i = 0; i < WORDS; i++) begin
      ref_a[i] = (a_mode < 0) ? i : a_mode;
      ref_b[i] = b;
      ref_c[i] = c;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < WORDS; i++) begin
      ref_a[i] = int'($urandom_range(0, 255));
      ref_b[i] = int'($urandom_range(0, 255));
      ref_c[i] = int'($urandom_range(0, 65535));
    end
  endtask

  initial begin
    Mem_reset                 = 1'b1;
    Comp_reset                = 1'b1;
    PE_reset                  = 1'b1;
    Mem_Index_reset           = 1'b0;
    bus.Computing             = 1'b0;
    bus.load_old_output       = 1'b0;
    bus.load_from_file        = 1'b0;
    bus.write_to_file         = 1'b0;
    bus.input_data_from_file  = '0;
    bus.output_data_from_file = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.state), 0);
    check("rst_index", 32'(bus.mem_index_test), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_we", 32'(bus.en_write_test), 0);
    check("rst_busy", 32'(bus.test_signal), 0);
    check("rst_out", 32'(bus.output_data_to_file), 0);
    check("rst_data", 32'(bus.test_data), 0);
    @(posedge clk); #1;
    Mem_reset  = 1'b0;
    Comp_reset = 1'b0;
    PE_reset   = 1'b0;

    // A=i, B=2, C=100, accumulate -> 2i+100
    fill_pattern(-1, 2, 100);
    load_vectors();
    run_compute(1'b1, 1'b0);
    run_dump();

    // Same load, overwrite -> 2i; Computing/load_from_file poked mid-run
    fill_pattern(-1, 2, 100);
    load_vectors();
    run_compute(1'b0, 1'b1);
    run_dump();

    // 255*255 + 65535 wraps to 65024
    fill_pattern(255, 255, 65535);
    load_vectors();
    run_compute(1'b1, 1'b0);
    run_dump();

    // Abort at step 10: only C[0..6] change
    fill_random();
    load_vectors();
    run_abort(1'($urandom_range(0, 1)));
    run_dump();

    // Random vectors, then a second accumulate pass on the same data
    repeat (3) begin
      fill_random();
      load_vectors();
      run_compute(1'($urandom_range(0, 1)), 1'b0);
      run_compute(1'b1, 1'b0);
      run_dump();
    end

    repeat (3) @(negedge clk);
    check("wb_queue_empty", exp_wb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
